decoder_3to8: RTL and testbench



---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_3to8_chk.sv | 16 +
 rtl/decoder_3to8_core.sv | 31 +++
 rtl/decoder_3to8.sv | 39 +++
 tb/tb_decoder_3to8.sv | 117 +++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and reference decode function for the 3-to-8 line decoder.
package decoder_pkg;

    localparam int DEC_SEL_W     = 3;
    localparam int DEC_OUT_W     = 8;
    localparam int DEC_MAX_SEL_W = 6;
    localparam int DEC_MAX_OUT_W = 64;

    // Sized for the widest legal select; callers keep the low 2**N bits.
    function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
        input logic [DEC_MAX_SEL_W-1:0] sel,
        input logic                     en
    );
        logic [DEC_MAX_OUT_W-1:0] word;
        word = {DEC_MAX_OUT_W{1'b0}};
        case (en)
            1'b1:    word[sel] = 1'b1;
            default: word = {DEC_MAX_OUT_W{1'b0}};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/decoder_3to8_chk.sv
// Property checker bound inside the decoder: output is one-hot0 and zero under reset.
module decoder_3to8_chk #(
    parameter int OUT_W = 8
) (
    input logic             clk,
    input logic             rst,
    input logic [OUT_W-1:0] y
);

    a_onehot0: assert property (@(posedge clk) $onehot0(y))
        else $error("decoder output not one-hot0: %b", y);

    a_reset_zero: assert property (@(posedge clk) rst |-> (y == {OUT_W{1'b0}}))
        else $error("decoder output nonzero during reset: %b", y);

endmodule

// File: rtl/decoder_3to8_core.sv
// Combinational select-to-one-hot decode; unknown selects or a low enable yield zero.
module decoder_3to8_core
    import decoder_pkg::*;
#(
    parameter int N = DEC_SEL_W
) (
    input  logic                E,
    input  logic [N-1:0]        w,
    output logic [(2**N)-1:0]   y_next
);

    localparam int OUT_W = 2**N;

    // An X/Z select fails every equality compare, so no bit is raised.
    always_comb begin
        y_next = {OUT_W{1'b0}};
        case (E)
            1'b1: begin
                for (int i = 0; i < OUT_W; i++) begin
                    if (w == N'(i)) begin
                        y_next[i] = 1'b1;
                    end else begin
                        y_next[i] = 1'b0;
                    end
                end
            end
            default: y_next = {OUT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/decoder_3to8.sv
// Registered N-to-2**N line decoder with active-high enable and async reset.
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int N = DEC_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic [N-1:0]        w,
    output logic [(2**N)-1:0]   y
);

    localparam int OUT_W = 2**N;

    logic [OUT_W-1:0] y_next_s;

    decoder_3to8_core #(.N(N)) u_core (
        .E      (E),
        .w      (w),
        .y_next (y_next_s)
    );

    // Output register: reset clears the word immediately, otherwise load every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= {OUT_W{1'b0}};
        end else begin
            y <= y_next_s;
        end
    end

    decoder_3to8_chk #(.OUT_W(OUT_W)) u_chk (
        .clk (clk),
        .rst (rst),
        .y   (y)
    );

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed and random self-checking bench for decoder_3to8 at the default width.
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic       E;
    logic [2:0] w;
    logic [7:0] y;

    int checks;
    int errors;

    decoder_3to8 #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .E   (E),
        .w   (w),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply E/w at the falling edge, then settle just past the next rising edge.
    task automatic step(input logic e_in, input logic [2:0] w_in);
        @(negedge clk);
        E = e_in;
        w = w_in;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] exp_v;
    logic       e_r;
    logic [2:0] w_r;

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst = 1'b1;
        E   = 1'b1;
        w   = 3'b101;
        #1;
        check("reset_initial", y, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held", y, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", y, 8'h20);

        // Mid-cycle reset must clear y without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", y, 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold_edge", y, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_resume", y, 8'h20);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'(i));
            check($sformatf("disabled_w%0d", i), y, 8'h00);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i));
            check($sformatf("enabled_w%0d", i), y, sweep_exp[i]);
        end

        step(1'b1, 3'b011);
        check("toggle_on1", y, 8'h08);
        step(1'b0, 3'b011);
        check("toggle_off", y, 8'h00);
        step(1'b1, 3'b011);
        check("toggle_on2", y, 8'h08);

        step(1'b0, 3'b111);
        check("simul_before", y, 8'h00);
        step(1'b1, 3'b010);
        check("simul_after", y, 8'h04);
        #3;
        check("simul_stable", y, 8'h04);

        for (int i = 0; i < 1000; i++) begin
            e_r = 1'($urandom_range(0, 1));
            w_r = 3'($urandom_range(0, 7));
            step(e_r, w_r);
            exp_v = e_r ? (8'h01 << w_r) : 8'h00;
            check("random_decode", y, exp_v);
            check("random_onehot0", {7'b0000000, $onehot0(y)}, 8'h01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
